// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: NDIG packed BCD digits -> unsigned binary, MSD first, one digit per clock; BCD2BIN_SAT_EN adds digit clamp + saturation.
// Latency: start sampled at edge 0, done after edge NDIG+1; start is ignored while busy (not queued), no backpressure.
module bcd2bin_seq #(
   parameter int NDIG  = 3,
   parameter int BIN_W = 10
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              busy,
   output logic              done,
   output logic [BIN_W-1:0]  binary_out,
   output logic              err
);

   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(NDIG - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   logic [1:0]        state;
   logic [4*NDIG-1:0] bcd_q;
   logic [IDX_W-1:0]  idx;
   logic [BIN_W-1:0]  acc;
   logic [BIN_W-1:0]  acc_nxt;
   logic              err_acc;
   logic [3:0]        dig;

   always_comb begin
      dig = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IDX_W'(i)) dig = bcd_q[4*i +: 4];
      end
   end

`ifdef BCD2BIN_SAT_EN
   logic [3:0]       dig_use;
   logic [BIN_W+3:0] wide;

   // Once acc reaches all-ones, acc*10 always exceeds it again, so saturation sticks.
   always_comb begin
      dig_use = (dig > 4'd9) ? 4'd9 : dig;
      wide    = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{BIN_W{1'b0}}, dig_use};
      acc_nxt = (wide > {4'b0, {BIN_W{1'b1}}}) ? {BIN_W{1'b1}} : wide[BIN_W-1:0];
   end
`else
   always_comb begin
      acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(dig);
   end
`endif

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bcd_q      <= '0;
         idx        <= '0;
         acc        <= '0;
         err_acc    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         binary_out <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  bcd_q   <= bcd_in;
                  acc     <= '0;
                  idx     <= IDX_MSD;
                  err_acc <= 1'b0;
                  busy    <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               acc     <= acc_nxt;
               err_acc <= err_acc | (dig > 4'd9);
               if (idx == '0) state <= S_FINISH;
               else           idx   <= idx - 1'b1;
            end
            S_FINISH: begin
               binary_out <= acc;
               err        <= err_acc;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: NDIG=3/BIN_W=10 main instance plus a BIN_W=8 instance for wrap/saturation.
module tb_bcd2bin_seq;

   logic        CLOCK_50 = 1'b0;
   logic        rst_n;
   logic        start;
   logic [11:0] bcd_in;
   logic        busy;
   logic        done;
   logic [9:0]  binary_out;
   logic        err;

   logic        start8;
   logic [11:0] bcd8;
   logic        busy8;
   logic        done8;
   logic [7:0]  binary8;
   logic        err8;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;
   int cnt;

`ifdef BCD2BIN_SAT_EN
   localparam int EXP_1A5 = 195;
   localparam int EXP_300 = 255;
`else
   localparam int EXP_1A5 = 205;
   localparam int EXP_300 = 44;
`endif

   bcd2bin_seq #(.NDIG(3), .BIN_W(10)) dut (
      .CLOCK_50   (CLOCK_50),
      .rst_n      (rst_n),
      .start      (start),
      .bcd_in     (bcd_in),
      .busy       (busy),
      .done       (done),
      .binary_out (binary_out),
      .err        (err)
   );

   bcd2bin_seq #(.NDIG(3), .BIN_W(8)) dut8 (
      .CLOCK_50   (CLOCK_50),
      .rst_n      (rst_n),
      .start      (start8),
      .bcd_in     (bcd8),
      .busy       (busy8),
      .done       (done8),
      .binary_out (binary8),
      .err        (err8)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One-cycle start pulse, then count edges after the start sample until done (bounded).
   task automatic run_conv(input logic [11:0] v, output int edges);
      start  = 1'b1;
      bcd_in = v;
      tick();
      start  = 1'b0;
      edges  = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         edges++;
         if (done) break;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = '0;
      start8 = 1'b0;
      bcd8   = '0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bin",  binary_out, 0);
      check("rst_err",  err, 0);
      rst_n = 1'b1;
      tick();

      // 999 with explicit per-cycle busy/done timing
      start  = 1'b1;
      bcd_in = 12'h999;
      tick();
      start = 1'b0;
      check("999_busy_e0", busy, 1);
      tick();
      check("999_busy_e1", busy, 1);
      tick();
      check("999_busy_e2", busy, 1);
      tick();
      check("999_busy_e3", busy, 1);
      check("999_done_e3", done, 0);
      tick();
      check("999_done_e4", done, 1);
      check("999_busy_e4", busy, 0);
      check("999_bin", binary_out, 999);
      check("999_err", err, 0);
      tick();
      check("999_done_e5", done, 0);
      check("999_hold", binary_out, 999);

      run_conv(12'h000, lat);
      check("000_lat", lat, 4);
      check("000_bin", binary_out, 0);
      check("000_err", err, 0);

      run_conv(12'h1A5, lat);
      check("1a5_lat", lat, 4);
      check("1a5_bin", binary_out, EXP_1A5);
      check("1a5_err", err, 1);
      tick();
      check("1a5_err_hold", err, 1);

      // start held high; bcd_in changes after the first start sample
      start  = 1'b1;
      bcd_in = 12'h255;
      tick();
      bcd_in = 12'h128;
      tick();
      tick();
      tick();
      tick();
      check("b2b_done1", done, 1);
      check("b2b_bin1", binary_out, 255);
      check("b2b_err1", err, 0);
      tick();
      check("b2b_busy2", busy, 1);
      check("b2b_done_gap", done, 0);
      start = 1'b0;
      tick();
      tick();
      tick();
      check("b2b_nodone_e8", done, 0);
      tick();
      check("b2b_done2", done, 1);
      check("b2b_bin2", binary_out, 128);

      // start pulsed while busy, bcd_in altered during CALC
      tick();
      start  = 1'b1;
      bcd_in = 12'h321;
      tick();
      start  = 1'b0;
      bcd_in = 12'h987;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("ign_done", done, 1);
      check("ign_bin", binary_out, 321);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) cnt++;
      end
      check("ign_no_extra", cnt, 0);

      // BIN_W=8 instance: 300 wraps to 44, or saturates to 255
      start8 = 1'b1;
      bcd8   = 12'h300;
      tick();
      start8 = 1'b0;
      lat    = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         lat++;
         if (done8) break;
      end
      check("w8_lat", lat, 4);
      check("w8_bin", binary8, EXP_300);
      check("w8_err", err8, 0);

      // give the main instance a nonzero, erroring result before the reset test
      run_conv(12'h1A5, lat);
      check("pre_rst_err", err, 1);

      // async reset in the middle of CALC
      start  = 1'b1;
      bcd_in = 12'h999;
      tick();
      start = 1'b0;
      tick();
      #5;
      rst_n = 1'b0;
      #2;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_bin",  binary_out, 0);
      check("arst_err",  err, 0);
      tick();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) cnt++;
      end
      check("arst_no_done", cnt, 0);
      check("arst_bin_hold", binary_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
